// File: rtl/ic74x161_pkg.sv
// rtl/ic74x161_pkg.sv - count width, terminal value and next-count rule for the 74LS161 model
package ic74x161_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  // Load beats counting; counting needs both enables; otherwise hold.
  function automatic logic [CNT_W-1:0] count_next(
    input logic [CNT_W-1:0] q,
    input logic             load_n,
    input logic             enp,
    input logic             ent,
    input logic [CNT_W-1:0] d
  );
    logic [CNT_W-1:0] nxt;
    nxt = q;
    if (!load_n) begin
      nxt = d;
    end else if (enp && ent) begin
      nxt = q + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ic74x161.sv
// rtl/ic74x161.sv - pin-accurate 74LS161 4-bit synchronous counter, async clear, sync load
module ic74x161
  import ic74x161_pkg::*;
#(
  parameter int CHECK_X = 1
) (
  input  logic port1,
  input  logic port2,
  input  logic port3,
  input  logic port4,
  input  logic port5,
  input  logic port6,
  input  logic port7,
  input  logic port8,
  input  logic port9,
  input  logic port10,
  output logic port11,
  output logic port12,
  output logic port13,
  output logic port14,
  output logic port15,
  input  logic port16
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;
  logic             unused_pwr;

  assign unused_pwr = port8 ^ port16;

  always_comb begin
    q_d = count_next(q_q, port9, port7, port10, {port6, port5, port4, port3});
  end

  // Holding port1 low keeps the register cleared, so edges during clear are lost.
  always_ff @(posedge port2 or negedge port1) begin
    if (!port1) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  always_comb begin
    port11 = q_q[3];
    port12 = q_q[2];
    port13 = q_q[1];
    port14 = q_q[0];
  end

  always_comb begin
    port15 = port10 & (q_q == CNT_MAX);
  end

  generate
    if (CHECK_X != 0) begin : g_xchk
      always @(posedge port2) begin
        if (port1 === 1'b1 && $isunknown({port7, port9, port10})) begin
          $fatal(1, "74*161 control X/Z");
        end
      end
    end
  endgenerate

endmodule
